// File: rtl/bsg_cordic_tanh_divide.sv
// Computes tanh = sinh/cosh by radix-2 restoring division (one quotient bit per cycle)
// and exp = cosh + sinh, behind val/ready handshakes on both sides.
`timescale 1ns/1ps
module bsg_cordic_tanh_divide #(
  parameter int ans_width_p = 32,
  parameter int frac_p      = 24
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [ans_width_p-1:0] sinh_i,
  input  logic signed [ans_width_p-1:0] cosh_i,
  input  logic                          val_i,
  output logic                          ready_o,
  output logic signed [ans_width_p-1:0] tanh_o,
  output logic signed [ans_width_p:0]   exp_o,
  output logic                          val_o,
  input  logic                          ready_i
);

  localparam int cnt_w = (frac_p > 1) ? $clog2(frac_p) : 1;
  localparam logic [ans_width_p-1:0] sat_mag = {{(ans_width_p-frac_p){1'b0}}, {frac_p{1'b1}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_r, state_n;
  logic                   sign_r, sat_r;
  logic [ans_width_p-1:0] rem_r, div_r;
  logic [frac_p-1:0]      q_r;
  logic [cnt_w-1:0]       cnt_r;

  logic                   accept, retire, last_step;
  logic [ans_width_p-1:0] mag_in;
  logic                   sat_in;
  logic [ans_width_p:0]   r2;
  logic                   take;
  logic [frac_p-1:0]      q_nx;
  logic [ans_width_p-1:0] mag_out;

  assign ready_o = (state_r == IDLE);
  assign val_o   = (state_r == DONE);
  assign accept  = ready_o & val_i;
  assign retire  = val_o & ready_i;
  assign last_step = (cnt_r == '0);

  // |sinh| as unsigned; the most-negative input naturally maps to 2^(w-1)
  assign mag_in = sinh_i[ans_width_p-1] ? $unsigned(-sinh_i) : $unsigned(sinh_i);
  assign sat_in = cosh_i[ans_width_p-1] | (cosh_i == '0) | (mag_in >= $unsigned(cosh_i));

  assign r2      = {rem_r, 1'b0};
  assign take    = (r2 >= {1'b0, div_r});
  assign q_nx    = (q_r << 1) | frac_p'(take);
  assign mag_out = sat_r ? sat_mag : {{(ans_width_p-frac_p){1'b0}}, q_nx};

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (val_i) state_n = BUSY;
      BUSY:    if (last_step) state_n = DONE;
      DONE:    if (ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sign_r <= 1'b0;
      sat_r  <= 1'b0;
      rem_r  <= '0;
      div_r  <= '0;
      q_r    <= '0;
      cnt_r  <= '0;
      tanh_o <= '0;
      exp_o  <= '0;
    end else if (accept) begin
      sign_r <= sinh_i[ans_width_p-1];
      sat_r  <= sat_in;
      rem_r  <= mag_in;
      div_r  <= cosh_i;
      q_r    <= '0;
      cnt_r  <= cnt_w'(frac_p-1);
      exp_o  <= {cosh_i[ans_width_p-1], cosh_i} + {sinh_i[ans_width_p-1], sinh_i};
    end else if (state_r == BUSY) begin
      // remainder stays below div for legal inputs, so dropping the top bit is lossless
      rem_r <= take ? ans_width_p'(r2 - {1'b0, div_r}) : r2[ans_width_p-1:0];
      q_r   <= q_nx;
      if (last_step) tanh_o <= sign_r ? -mag_out : mag_out;
      else           cnt_r  <= cnt_r - 1'b1;
    end
  end

endmodule
